cpu_run_ctrl: RTL and testbench

Parametrised run-control sequencer placed between the system clock/reset and the MIPS16 CPU core. It holds the core in reset for a programmable number of cycles and then gates execution through a clock enable. Execution modes are run-N-cycles, free-run, and single-step. It reports busy, done and an executed-cycle count, which makes bring-up and regression runs self-terminating in hardware.

---
 rtl/cpu_run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run-control sequencer in front of the MIPS16 core.
// Holds the core in reset for RST_CYCLES after a start, then gates execution
// through cpu_en in run-N, free-run or single-step mode. It reports busy,
// done and the number of enabled cycles.
// Optional breakpoint support (bp_hit input, sticky bp_flag output) is
// compiled in when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int CNT_W          = 16,
  parameter int RST_CYCLES     = 1,
  parameter int DEFAULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] cycles,
  input  logic             step,
  input  logic             halt,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  input  logic             bp_hit,
  output logic             bp_flag,
`endif
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST      = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(DEFAULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             cpu_en_q, cpu_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             stop_req;
  logic             term_hit;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic             bp_flag_q, bp_flag_d;
  logic             bp_stop;
`endif

  // Next-state, latched-configuration and registered-output computation
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    limit_d   = limit_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    cpu_en_d  = 1'b0;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    bp_flag_d = bp_flag_q;
    bp_stop   = bp_hit && cpu_en_q && ((state_q == ST_RUN) || (state_q == ST_STEP));
    stop_req  = halt || bp_stop;
`else
    stop_req  = halt;
`endif

    // Every edge the core actually advances on is counted; the count
    // saturates rather than wrapping in long free runs.
    if (cpu_en_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Terminal count: this enabled edge is the last one of a run-N run.
    term_hit = (mode_q != MODE_FREE) && cpu_en_q && (cnt_q == (limit_q - 1'b1));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RESET;
          mode_d    = mode;
          limit_d   = (cycles == '0) ? DEFAULT_LIMIT : cycles;
          rst_cnt_d = '0;
          cnt_d     = '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
          bp_flag_d = 1'b0;
`endif
        end
      end

      ST_RESET: begin
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d  = (mode_q == MODE_STEP) ? ST_STEP : ST_RUN;
          cpu_en_d = (mode_q != MODE_STEP);
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (stop_req || term_hit) begin
          state_d = ST_DONE;
        end else begin
          cpu_en_d = 1'b1;
        end
      end

      ST_STEP: begin
        if (stop_req) begin
          state_d = ST_DONE;
        end else if (step && !cpu_en_q) begin
          cpu_en_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    if (bp_stop) begin
      bp_flag_d = 1'b1;
    end
`endif

    // Status outputs follow the state being entered so they stay registered.
    cpu_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    busy_d    = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_STEP);
    done_d    = (state_d == ST_DONE);
  end

  // State, configuration and output registers with asynchronous reset to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= 2'b00;
      limit_q   <= DEFAULT_LIMIT;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      cpu_rst_q <= 1'b1;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_flag_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      limit_q   <= limit_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      cpu_rst_q <= cpu_rst_d;
      cpu_en_q  <= cpu_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_flag_q <= bp_flag_d;
`endif
    end
  end

  assign cpu_rst     = cpu_rst_q;
  assign cpu_en      = cpu_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cnt_q;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  assign bp_flag     = bp_flag_q;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: bench for cpu_run_ctrl. Two instances are used: dut_a with
// RST_CYCLES=1 / CNT_W=16 and dut_b with RST_CYCLES=2 / CNT_W=8 (for
// saturation). 'sel' routes the pulse inputs and the observed outputs.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        halt = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] cycles = 16'd0;

  logic        a_cpu_rst, a_cpu_en, a_busy, a_done;
  logic [15:0] a_cnt;
  logic        b_cpu_rst, b_cpu_en, b_busy, b_done;
  logic [7:0]  b_cnt;

  logic        obs_rst, obs_en, obs_busy, obs_done;
  logic [15:0] obs_cnt;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic bp_hit = 1'b0;
  logic a_bp_flag, b_bp_flag;
`endif

  cpu_run_ctrl #(.CNT_W(16), .RST_CYCLES(1), .DEFAULT_CYCLES(5)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .mode(mode), .cycles(cycles),
    .step(step & ~sel), .halt(halt & ~sel),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    .bp_hit(bp_hit & ~sel), .bp_flag(a_bp_flag),
`endif
    .cpu_rst(a_cpu_rst), .cpu_en(a_cpu_en), .busy(a_busy), .done(a_done),
    .cycle_count(a_cnt)
  );

  cpu_run_ctrl #(.CNT_W(8), .RST_CYCLES(2), .DEFAULT_CYCLES(5)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .mode(mode), .cycles(cycles[7:0]),
    .step(step & sel), .halt(halt & sel),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    .bp_hit(bp_hit & sel), .bp_flag(b_bp_flag),
`endif
    .cpu_rst(b_cpu_rst), .cpu_en(b_cpu_en), .busy(b_busy), .done(b_done),
    .cycle_count(b_cnt)
  );

  assign obs_rst  = sel ? b_cpu_rst : a_cpu_rst;
  assign obs_en   = sel ? b_cpu_en  : a_cpu_en;
  assign obs_busy = sel ? b_busy    : a_busy;
  assign obs_done = sel ? b_done    : a_done;
  assign obs_cnt  = sel ? {8'h00, b_cnt} : a_cnt;

  always #5 clk = ~clk;

  // Hard stop if the directed sequence ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] m, input logic [15:0] c,
                               input logic st, input logic h);
    start  = s;
    mode   = m;
    cycles = c;
    step   = st;
    halt   = h;
    tick();
    start = 1'b0;
    step  = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic e_rst, input logic e_en,
                            input logic e_busy, input logic e_done, input int e_cnt);
    checkOutput({tag, ".cpu_rst"}, {15'd0, obs_rst}, {15'd0, e_rst});
    checkOutput({tag, ".cpu_en"},  {15'd0, obs_en},  {15'd0, e_en});
    checkOutput({tag, ".busy"},    {15'd0, obs_busy}, {15'd0, e_busy});
    checkOutput({tag, ".done"},    {15'd0, obs_done}, {15'd0, e_done});
    checkOutput({tag, ".count"},   obs_cnt, 16'(e_cnt));
  endtask

  // Run-N / free-run timeline model: reset phase of R cycles, then one
  // enabled cycle per clock until the limit (run-N) or a halt ends the run.
  task automatic runN(input string tag, input logic [1:0] m, input logic [15:0] c,
                      input int haltAt, input int midStart);
    int r, lim, t, cnt;
    bit free, fin, h;
    r    = sel ? 2 : 1;
    lim  = (c == 16'd0) ? 5 : int'(c);
    free = (m == 2'b01);
    applyStimulus(1'b1, m, c, 1'b0, 1'b0);
    cnt = 0;
    t   = 1;
    fin = 1'b0;
    while (!fin) begin
      if (t <= r) checkState(tag, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      else        checkState(tag, 1'b0, 1'b1, 1'b1, 1'b0, cnt);
      h = (t == haltAt);
      applyStimulus(t == midStart, ~m, c + 16'd7, 1'b0, h);
      if (t > r) cnt++;
      if (h || (!free && (t > r) && (cnt == lim))) fin = 1'b1;
      t++;
    end
    checkState({tag, ".end"}, 1'b0, 1'b0, 1'b0, 1'b1, cnt);
    applyStimulus(1'b0, m, c, 1'b0, 1'b1);
    checkState({tag, ".halt_in_done"}, 1'b0, 1'b0, 1'b0, 1'b1, cnt);
  endtask

  // Single-step model: each accepted step gives one enabled cycle; odd-numbered
  // steps hold step high a second cycle, which must be ignored.
  task automatic stepRun(input string tag, input int nsteps, input int spacing);
    int r, cnt;
    r   = sel ? 2 : 1;
    cnt = 0;
    applyStimulus(1'b1, 2'b10, 16'd0, 1'b0, 1'b0);
    for (int t = 1; t <= r; t++) begin
      checkState({tag, ".rst"}, 1'b1, 1'b0, 1'b1, 1'b0, 0);
      applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
    end
    checkState({tag, ".wait"}, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 0; k < nsteps; k++) begin
      applyStimulus(1'b0, 2'b10, 16'd0, 1'b1, 1'b0);
      checkState({tag, ".pulse"}, 1'b0, 1'b1, 1'b1, 1'b0, cnt);
      applyStimulus(1'b0, 2'b10, 16'd0, (k % 2) == 1, 1'b0);
      cnt++;
      checkState({tag, ".after"}, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
      for (int i = 2; i < spacing; i++) begin
        applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
        checkState({tag, ".gap"}, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
      end
    end
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b1, 1'b1);
    checkState({tag, ".step_halt"}, 1'b0, 1'b0, 1'b0, 1'b1, cnt);
  endtask

  // Directed and randomized sequence
  initial begin
    int r, m_sel, ha, ms;
    logic [1:0]  m;
    logic [15:0] c;

    #2 rst = 1'b0;
    #2;
    sel = 1'b0; checkState("reset_a", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sel = 1'b1; checkState("reset_b", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sel = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    checkState("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 16'd0, 1'b0, 1'b1);
    checkState("halt_in_idle", 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Default run length, then a two-run sequence with a longer reset
    sel = 1'b0; runN("t1", 2'b00, 16'd0, 0, 0);
    sel = 1'b1; runN("t2a", 2'b00, 16'd3, 0, 0);
    runN("t2b", 2'b00, 16'd3, 0, 0);

    // Single-step on both instances
    sel = 1'b0; stepRun("t3a", 4, 3);
    sel = 1'b1; stepRun("t3b", 3, 4);

    // Free-run halted after 10 enabled cycles with a start attempted mid-run
    sel = 1'b0; runN("t4", 2'b01, 16'd0, 11, 6);

    // Randomized runs: mode 00/01/11, random limit, halt point and stray start
    for (int n = 0; n < 10; n++) begin
      sel   = 1'($urandom_range(0, 1));
      m_sel = $urandom_range(0, 2);
      m     = (m_sel == 0) ? 2'b00 : ((m_sel == 1) ? 2'b01 : 2'b11);
      c     = 16'($urandom_range(0, 30));
      ha    = $urandom_range(1, 45);
      ms    = $urandom_range(1, 20);
      runN("rand", m, c, ha, ms);
    end

    // Saturation of the 8-bit counter in free-run
    sel = 1'b1;
    applyStimulus(1'b1, 2'b01, 16'd0, 1'b0, 1'b0);
    r = 2;
    for (int i = 0; i < r + 300; i++) applyStimulus(1'b0, 2'b01, 16'd0, 1'b0, 1'b0);
    checkState("sat_run", 1'b0, 1'b1, 1'b1, 1'b0, 255);
    applyStimulus(1'b0, 2'b01, 16'd0, 1'b0, 1'b1);
    checkState("sat_done", 1'b0, 1'b0, 1'b0, 1'b1, 255);

    // Asynchronous reset in the middle of a long run-N run
    sel = 1'b0;
    applyStimulus(1'b1, 2'b00, 16'd100, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, 2'b00, 16'd100, 1'b0, 1'b0);
    checkState("pre_rst", 1'b0, 1'b1, 1'b1, 1'b0, 20);
    #2 rst = 1'b0;
    #1;
    checkState("mid_rst_a", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sel = 1'b1;
    checkState("mid_rst_b", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    sel = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    checkState("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 0);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint on the 7th enabled cycle of a free run
    sel = 1'b0;
    applyStimulus(1'b1, 2'b01, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 2'b01, 16'd0, 1'b0, 1'b0);
    checkState("bp_pre", 1'b0, 1'b1, 1'b1, 1'b0, 6);
    bp_hit = 1'b1;
    applyStimulus(1'b0, 2'b01, 16'd0, 1'b0, 1'b0);
    bp_hit = 1'b0;
    checkState("bp_done", 1'b0, 1'b0, 1'b0, 1'b1, 7);
    checkOutput("bp_flag_set", {15'd0, a_bp_flag}, 16'd1);
    applyStimulus(1'b1, 2'b00, 16'd2, 1'b0, 1'b0);
    checkOutput("bp_flag_clr", {15'd0, a_bp_flag}, 16'd0);
    checkState("bp_restart", 1'b1, 1'b0, 1'b1, 1'b0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
